action_scheduler: RTL
=====================

# action_scheduler

Arbitrates all falling-tetromino movement requests (user moves, rotations, soft/hard drop, gravity ticks) into a single serialized action stream for the collision-check/move datapath. It sits between the input debouncers and the playfield move logic, and alongside the game-state FSM. It generates the gravity tick internally. It feeds the FSM's `user_input` and `hard_drop` inputs. It blocks actions between piece lock and the next spawn.

## Interface
- `GRAVITY_PERIOD`, 50_000_000: gravity interval in clk cycles at level 0.
- `GRAVITY_STEP`, 3_000_000: cycles subtracted per level (only with `ACTION_SCHED_LEVEL_EN`).
- `GRAVITY_MIN`, 2_000_000: floor on the gravity interval.

Ports:
- `clk`  in  1  system clock.
- `rst_l`  in  1  asynchronous, active-low reset.
- `game_active`  in  1  high while the game FSM is not IDLE.
- `new_tetromino`  in  1  one-cycle pulse when a new piece spawns.
- `falling_piece_lock`  in  1  one-cycle pulse when the piece locks.
- `mv_left`, `mv_right`, `rot_cw`, `rot_ccw`, `soft_drop`, `hard_drop_req`  in  1 each  one-cycle request pulses.
- `level`  in  4  current game level.
- `act_valid`  out  1  action offered to the datapath.
- `act_type`  out  3  action code: 0 GRAVITY, 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 SOFT, 6 HARD.
- `act_ready`  in  1  datapath accepts the action this cycle.
- `user_input`  out  1  one-cycle pulse when any non-gravity action is accepted.
- `hard_drop`  out  1  one-cycle pulse when a HARD action is accepted.

## Operation
- Each action type has one pending bit.
  - A request pulse sets its bit; repeat requests while the bit is set coalesce.
  - Acceptance (`act_valid && act_ready`) clears the accepted bit.
  - A new request for the same type in the acceptance cycle wins: the bit stays set.
- `mv_left` and `mv_right` in the same cycle cancel each other; neither bit changes.
- Gravity counter:
  - 32-bit down-counter, active only in ARMED or ISSUE.
  - On reaching 0 it sets the GRAVITY pending bit and reloads the period.
  - Acceptance of SOFT also reloads the counter and clears the GRAVITY pending bit.
- Priority, highest first: HARD, ROT_CW, ROT_CCW, LEFT, RIGHT, SOFT, GRAVITY.
- State machine:
  - IDLE: all pending bits clear. Goes to LOCKED when `game_active` rises.
  - LOCKED: requests are ignored and pending bits held clear. Goes to ARMED on `new_tetromino`; the gravity counter reloads on entry to ARMED.
  - ARMED: if any bit is pending, register the highest-priority type into `act_type`, assert `act_valid`, and go to ISSUE.
  - ISSUE: hold `act_valid` and `act_type` stable until accepted.
    - On acceptance of HARD, go to LOCKED.
    - On any other acceptance, go to ARMED.
- Overrides, in precedence order:
  - `game_active` low → IDLE, from any state.
  - `falling_piece_lock` → LOCKED, from any state.
  - Both overrides clear `act_valid` and all pending bits immediately. These are the only legal withdrawals of a valid action.
- `new_tetromino` in ARMED or ISSUE aborts the same way, then enters ARMED.
- Gravity period:
  - Without the macro: `GRAVITY_PERIOD`.
  - With the macro: `max(GRAVITY_PERIOD − level·GRAVITY_STEP, GRAVITY_MIN)`, computed in 32 bits with no underflow (saturate before subtracting).

## Timing
- Reset values:
  - state IDLE.
  - `act_valid`=0, `act_type`=0, `user_input`=0, `hard_drop`=0.
  - Pending bits 0.
  - Gravity counter loaded with the level-0 period.
- All outputs are registered.
- Latency: a request sampled at edge k sets pending after k, and `act_valid` is asserted after edge k+1 (2 cycles), provided the scheduler is in ARMED with nothing of higher priority pending.
- Throughput: at most one acceptance every 2 cycles (ISSUE→ARMED→ISSUE).
- `user_input` and `hard_drop` assert the cycle after the accepting edge, for exactly one cycle.
- The gravity tick is recorded in pending the cycle after the counter reads 0. The period therefore counts `period+1` cycles from reload to pending.
- A `level` change takes effect at the next reload only.

## Configuration
- `ACTION_SCHED_LEVEL_EN`:
  - Defined: gravity period is scaled by `level` as above.
  - Undefined: `level` is ignored and the period is always `GRAVITY_PERIOD`.

## Test plan
- Reset, then `game_active`=1 and `new_tetromino` pulse, then `mv_left` pulse with `act_ready`=1 → `act_valid`=1, `act_type`=1 two cycles after the pulse; `user_input` pulses once.
- `hard_drop_req`, `rot_cw` and `mv_right` in one cycle, `act_ready`=1 → HARD issued first, then `hard_drop` pulse, then LOCKED. ROT_CW and RIGHT are discarded; no further `act_valid` until `new_tetromino`.
- `mv_left` and `mv_right` in the same cycle → no action issued. `act_ready` held 0 with ROT_CW pending → `act_valid`/`act_type`=3 stable for 10 cycles, then accepted once.
- `GRAVITY_PERIOD`=20, no user input → GRAVITY (`act_type`=0) issued every 21 cycles; a SOFT acceptance restarts the interval.
- With macro, `GRAVITY_PERIOD`=20, `GRAVITY_STEP`=3, `GRAVITY_MIN`=4, `level`=15 → interval uses the 4-cycle floor. Without macro, the same stimulus gives a 20-cycle period.
- `falling_piece_lock` while `act_valid`=1 → `act_valid`=0 the next cycle and pending cleared. `rst_l` low mid-ISSUE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/action_scheduler.sv
// Serializes tetromino moves, rotations, drops and internal gravity ticks into one action stream.
// Latency: request pulse -> act_valid two edges later when ARMED. Backpressure: action held until act_ready.
// Define ACTION_SCHED_LEVEL_EN to shorten the gravity period with level.
module action_scheduler #(
    parameter int unsigned GRAVITY_PERIOD = 32'd50_000_000,
    parameter int unsigned GRAVITY_STEP   = 32'd3_000_000,
    parameter int unsigned GRAVITY_MIN    = 32'd2_000_000
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       game_active,
    input  logic       new_tetromino,
    input  logic       falling_piece_lock,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       rot_cw,
    input  logic       rot_ccw,
    input  logic       soft_drop,
    input  logic       hard_drop_req,
    input  logic [3:0] level,
    output logic       act_valid,
    output logic [2:0] act_type,
    input  logic       act_ready,
    output logic       user_input,
    output logic       hard_drop
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_ARMED, ST_ISSUE} state_t;

    localparam logic [2:0] A_GRAV  = 3'd0;
    localparam logic [2:0] A_LEFT  = 3'd1;
    localparam logic [2:0] A_RIGHT = 3'd2;
    localparam logic [2:0] A_CW    = 3'd3;
    localparam logic [2:0] A_CCW   = 3'd4;
    localparam logic [2:0] A_SOFT  = 3'd5;
    localparam logic [2:0] A_HARD  = 3'd6;

    state_t      state, state_nxt;
    logic [6:0]  pend, pend_nxt, req, clr;
    logic [31:0] grav_cnt, period;
    logic [2:0]  pick, act_type_nxt;
    logic        accept, run, spawn, soft_acc, reload, grav_tick;
    logic        act_valid_nxt, user_input_nxt, hard_drop_nxt;

`ifdef ACTION_SCHED_LEVEL_EN
    localparam logic [31:0] PERIOD0 = (GRAVITY_PERIOD > GRAVITY_MIN) ? GRAVITY_PERIOD : GRAVITY_MIN;
    logic [31:0] level_dec, period_sub;
    // Saturate at zero before applying the floor so high levels cannot wrap.
    always_comb begin
        level_dec  = 32'(level) * GRAVITY_STEP;
        period_sub = (GRAVITY_PERIOD > level_dec) ? GRAVITY_PERIOD - level_dec : 32'd0;
        period     = (period_sub > GRAVITY_MIN) ? period_sub : GRAVITY_MIN;
    end
`else
    localparam logic [31:0] PERIOD0 = GRAVITY_PERIOD;
    logic unused_level;
    assign unused_level = ^level;
    assign period       = GRAVITY_PERIOD;
`endif

    assign accept    = act_valid && act_ready;
    assign run       = (state == ST_ARMED) || (state == ST_ISSUE);
    assign spawn     = game_active && !falling_piece_lock && new_tetromino && (state != ST_IDLE);
    assign soft_acc  = accept && (act_type == A_SOFT);
    assign reload    = spawn || soft_acc;
    assign grav_tick = run && (grav_cnt == 32'd0) && !reload;

    always_comb begin
        pick = A_GRAV;
        if      (pend[A_HARD])  pick = A_HARD;
        else if (pend[A_CW])    pick = A_CW;
        else if (pend[A_CCW])   pick = A_CCW;
        else if (pend[A_LEFT])  pick = A_LEFT;
        else if (pend[A_RIGHT]) pick = A_RIGHT;
        else if (pend[A_SOFT])  pick = A_SOFT;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!game_active)            state_nxt = ST_IDLE;
        else if (falling_piece_lock) state_nxt = ST_LOCKED;
        else if (spawn)              state_nxt = ST_ARMED;
        else begin
            case (state)
                ST_IDLE:   state_nxt = ST_LOCKED;
                ST_LOCKED: state_nxt = ST_LOCKED;
                ST_ARMED:  if (|pend) state_nxt = ST_ISSUE;
                ST_ISSUE:  if (accept) state_nxt = (act_type == A_HARD) ? ST_LOCKED : ST_ARMED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        act_valid_nxt  = 1'b0;
        act_type_nxt   = act_type;
        user_input_nxt = accept && (act_type != A_GRAV);
        hard_drop_nxt  = accept && (act_type == A_HARD);
        if (state == ST_ARMED && state_nxt == ST_ISSUE) begin
            act_valid_nxt = 1'b1;
            act_type_nxt  = pick;
        end else if (state == ST_ISSUE && state_nxt == ST_ISSUE) begin
            act_valid_nxt = 1'b1;
        end
    end

    // Left and right together cancel; a same-cycle re-request beats the accept clear.
    always_comb begin
        req         = '0;
        req[A_GRAV] = grav_tick;
        req[A_LEFT] = mv_left & ~mv_right;
        req[A_RIGHT]= mv_right & ~mv_left;
        req[A_CW]   = rot_cw;
        req[A_CCW]  = rot_ccw;
        req[A_SOFT] = soft_drop;
        req[A_HARD] = hard_drop_req;
        clr         = '0;
        if (accept)   clr[act_type] = 1'b1;
        if (soft_acc) clr[A_GRAV]   = 1'b1;
        if (state_nxt == ST_IDLE || state_nxt == ST_LOCKED || spawn) pend_nxt = '0;
        else pend_nxt = (pend & ~clr) | req;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pend     <= '0;
            grav_cnt <= PERIOD0;
        end else begin
            pend <= pend_nxt;
            if (reload)   grav_cnt <= period;
            else if (run) grav_cnt <= (grav_cnt == 32'd0) ? period : grav_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            act_valid  <= 1'b0;
            act_type   <= A_GRAV;
            user_input <= 1'b0;
            hard_drop  <= 1'b0;
        end else begin
            act_valid  <= act_valid_nxt;
            act_type   <= act_type_nxt;
            user_input <= user_input_nxt;
            hard_drop  <= hard_drop_nxt;
        end
    end

endmodule
